grf: RTL and testbench
======================

Name: grf

Overview:
General-purpose register file for the single-cycle MIPS-style datapath. It holds 32 registers of 32 bits each and provides two combinational read ports and one synchronous write port. Register 0 is hardwired to zero. It sits between instruction decode (read addresses from rs/rt) and writeback (write address, data and enable from the control unit).

Parameters:
DATA_WIDTH, 32, width of each register and of the data ports.
ADDR_WIDTH, 5, register address width; depth is 2**ADDR_WIDTH (32 entries).
BYPASS, 0, read-during-write forwarding; 0 = off, 1 = on.

Ports:
clk  input  1  system clock; all writes occur on its rising edge.
reset  input  1  asynchronous, active-high; clears all registers to 0.
A1  input  ADDR_WIDTH  read address, port 1 (rs).
A2  input  ADDR_WIDTH  read address, port 2 (rt).
A3  input  ADDR_WIDTH  write address.
WD  input  DATA_WIDTH  write data.
WE  input  1  write enable, active-high.
RD1  output  DATA_WIDTH  read data for A1.
RD2  output  DATA_WIDTH  read data for A2.

Behaviour:
- Interface: one clock (clk). Reset (reset) is asynchronous and active-high.
- Storage: array of 2**ADDR_WIDTH registers of DATA_WIDTH bits. No other state.
- Reset:
  - When reset rises, all registers clear to 0 immediately, without waiting for a clock edge.
  - While reset is high, writes are ignored and all registers stay at 0.
  - Reset takes priority over a simultaneous write.
  - RD1 and RD2 therefore read 0 for every address during and right after reset.
- Write:
  - On a rising edge of clk with reset low, WE=1 and A3!=0, register[A3] <= WD.
  - With WE=0, nothing changes.
  - A3=0 with WE=1 is silently discarded; register 0 always reads 0.
  - One write per cycle; write latency is 1 edge.
- Read:
  - Purely combinational, zero-cycle latency.
  - RD1 = (A1==0) ? 0 : register[A1]; RD2 is the same for A2.
  - Both ports may address the same register, or the register being written, in the same cycle.
- BYPASS=0:
  - A read of A3 during a write cycle returns the old value until the clock edge.
  - After the edge it returns the new value in the same cycle's combinational settling.
- BYPASS=1:
  - If WE=1, A3!=0 and A1==A3, RD1 returns WD combinationally; likewise RD2 for A2.
  - Address 0 is never forwarded.
- Timing: no X on outputs after reset; inputs are sampled only at the clk rising edge (for writes).
- No simulation-side prints are required. An optional write trace (time, register, data) may be enabled by a non-synthesised define.

Test Plan:
1. Reset: pulse reset=1 mid-cycle (not aligned to clk) after registers hold data -> RD1 and RD2 read 0 immediately for A1=5 and A2=29, before any clk edge.
2. Zero register: WE=1, A3=0, WD=1, clock one edge; A1=0 -> RD1 stays 0.
3. Basic write/read: WE=1, A3=1, WD=1, edge; A2=1 -> RD2=1 right after the edge. Then A3=29, WD=2, edge; A3=5, WD=3, edge; then WE=0, A1=5, A2=29 -> RD1=3, RD2=2.
4. Write disabled: WE=0, A3=5, WD=0xFFFFFFFF, several edges -> RD1 (A1=5) remains 3.
5. Read-during-write:
   - BYPASS=0: A1=A3=7, WE=1, WD=0x12345678 -> RD1 shows the old value before the edge and 0x12345678 after it.
   - BYPASS=1: RD1=0x12345678 before the edge.
6. Reset vs write collision: reset=1 asserted across a rising clk with WE=1, A3=3, WD=9 -> register 3 reads 0 after reset deasserts.

Source files
------------

// File: rtl/grf.sv
// ---------------------------------------------------------------------------
// grf -- general-purpose register file for the single-cycle MIPS datapath.
//
// Holds 2**ADDR_WIDTH registers of DATA_WIDTH bits. It has two combinational
// read ports and one synchronous write port. Register 0 always reads as zero.
//
// Parameters:
//   DATA_WIDTH  width of each register and of the data ports
//   ADDR_WIDTH  register address width (depth = 2**ADDR_WIDTH)
//   BYPASS      1 = forward WD to a read port that addresses the register
//               being written in the same cycle; 0 = read the stored value
//
// Ports:
//   clk    in   system clock; writes happen on its rising edge
//   reset  in   asynchronous, active-high; clears every register to 0
//   A1     in   read address, port 1 (rs)
//   A2     in   read address, port 2 (rt)
//   A3     in   write address
//   WD     in   write data
//   WE     in   write enable, active-high
//   RD1    out  read data for A1
//   RD2    out  read data for A2
// ---------------------------------------------------------------------------
module grf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit BYPASS     = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    input  logic [ADDR_WIDTH-1:0] A3,
    input  logic [DATA_WIDTH-1:0] WD,
    input  logic                  WE,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    // Writes to register 0 are dropped here, so entry 0 only ever holds its
    // reset value; the read mux also forces 0 so the output never depends
    // on that.
    logic wr_en;
    assign wr_en = WE && (A3 != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[A3] <= WD;
        end
    end

    // Read port 1. wr_en already excludes A3 == 0, so address 0 is never
    // forwarded even when BYPASS is set.
    always_comb begin
        RD1 = (A1 == '0) ? '0 : regs[A1];
        if (BYPASS && wr_en && (A1 == A3)) begin
            RD1 = WD;
        end
    end

    // Read port 2, same rules as port 1.
    always_comb begin
        RD2 = (A2 == '0) ? '0 : regs[A2];
        if (BYPASS && wr_en && (A2 == A3)) begin
            RD2 = WD;
        end
    end

endmodule

// File: tb/tb_grf.sv
module tb_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  a1, a2, a3;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd1, rd2, brd1, brd2;

    // Reference: plain array of register contents, updated per clock edge.
    logic [31:0] model [32];

    int vectors    = 0;
    int miscompares = 0;

    grf #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) dut (
        .clk(clk), .reset(reset), .A1(a1), .A2(a2), .A3(a3),
        .WD(wd), .WE(we), .RD1(rd1), .RD2(rd2)
    );

    grf #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .reset(reset), .A1(a1), .A2(a2), .A3(a3),
        .WD(wd), .WE(we), .RD1(brd1), .RD2(brd2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : model[a];
    endfunction

    function automatic logic [31:0] exp_byp(input logic [4:0] a);
        if (we && a3 != 5'd0 && a == a3) return wd;
        return exp_rd(a);
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endfunction

    // Advance over one rising edge, apply the write rule to the model,
    // then settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        if (!reset && we && a3 != 5'd0) model[a3] = wd;
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            a1 = 5'(k * 9 + 2);
            a2 = 5'(31 - k * 7);
            #1;
            vectors += 2;
            if (rd1 !== 32'd0) begin miscompares++; $display("FAIL reset_rd1 a=%0d: got %h expected 0", a1, rd1); end
            if (rd2 !== 32'd0) begin miscompares++; $display("FAIL reset_rd2 a=%0d: got %h expected 0", a2, rd2); end
        end
        @(negedge clk);
        reset = 1'b0;
        a1 = 5'd31;
        #1;
        vectors++;
        if (brd1 !== 32'd0) begin miscompares++; $display("FAIL post_reset_byp_rd1: got %h expected 0", brd1); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        we = 1'b1; a3 = 5'd0; wd = 32'd1; a1 = 5'd0;
        #1;
        vectors++;
        if (brd1 !== 32'd0) begin miscompares++; $display("FAIL zero_no_forward: got %h expected 0", brd1); end
        tick();
        vectors += 2;
        if (rd1 !== 32'd0)  begin miscompares++; $display("FAIL zero_reg: got %h expected 0", rd1); end
        if (brd1 !== 32'd0) begin miscompares++; $display("FAIL zero_reg_byp: got %h expected 0", brd1); end
    endtask

    task automatic test_basic();
        @(negedge clk);
        we = 1'b1; a3 = 5'd1; wd = 32'd1; a2 = 5'd1;
        #1;
        vectors += 2;
        if (rd2 !== 32'd0)  begin miscompares++; $display("FAIL basic_pre_edge: got %h expected 0", rd2); end
        if (brd2 !== 32'd1) begin miscompares++; $display("FAIL basic_byp_pre_edge: got %h expected 1", brd2); end
        tick();
        vectors++;
        if (rd2 !== 32'd1) begin miscompares++; $display("FAIL basic_post_edge: got %h expected 1", rd2); end
        @(negedge clk); a3 = 5'd29; wd = 32'd2; tick();
        @(negedge clk); a3 = 5'd5;  wd = 32'd3; tick();
        @(negedge clk);
        we = 1'b0; a1 = 5'd5; a2 = 5'd29;
        #1;
        vectors += 4;
        if (rd1 !== 32'd3)  begin miscompares++; $display("FAIL basic_rd1: got %h expected 3", rd1); end
        if (rd2 !== 32'd2)  begin miscompares++; $display("FAIL basic_rd2: got %h expected 2", rd2); end
        if (brd1 !== 32'd3) begin miscompares++; $display("FAIL basic_byp_rd1: got %h expected 3", brd1); end
        if (brd2 !== 32'd2) begin miscompares++; $display("FAIL basic_byp_rd2: got %h expected 2", brd2); end
    endtask

    task automatic test_write_disable();
        @(negedge clk);
        we = 1'b0; a3 = 5'd5; wd = 32'hFFFF_FFFF; a1 = 5'd5;
        repeat (4) tick();
        vectors += 2;
        if (rd1 !== 32'd3)  begin miscompares++; $display("FAIL we_off: got %h expected 3", rd1); end
        if (brd1 !== 32'd3) begin miscompares++; $display("FAIL we_off_byp: got %h expected 3", brd1); end
    endtask

    task automatic test_rdw();
        logic [31:0] old;
        old = $urandom;
        @(negedge clk); we = 1'b1; a3 = 5'd7; wd = old; tick();
        @(negedge clk);
        a1 = 5'd7; a3 = 5'd7; we = 1'b1; wd = 32'h1234_5678;
        #1;
        vectors += 2;
        if (rd1 !== old)           begin miscompares++; $display("FAIL rdw_old: got %h expected %h", rd1, old); end
        if (brd1 !== 32'h12345678) begin miscompares++; $display("FAIL rdw_bypass: got %h expected 12345678", brd1); end
        tick();
        vectors += 2;
        if (rd1 !== 32'h12345678)  begin miscompares++; $display("FAIL rdw_new: got %h expected 12345678", rd1); end
        if (brd1 !== 32'h12345678) begin miscompares++; $display("FAIL rdw_byp_new: got %h expected 12345678", brd1); end
        @(negedge clk); we = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        we = 1'b0; a1 = 5'd5; a2 = 5'd29;
        #1;
        vectors += 2;
        if (rd1 !== exp_rd(5'd5))  begin miscompares++; $display("FAIL areset_pre_rd1: got %h expected %h", rd1, exp_rd(5'd5)); end
        if (rd2 !== exp_rd(5'd29)) begin miscompares++; $display("FAIL areset_pre_rd2: got %h expected %h", rd2, exp_rd(5'd29)); end
        @(posedge clk);
        #2;
        reset = 1'b1;
        clear_model();
        #1;
        vectors += 4;
        if (rd1 !== 32'd0)  begin miscompares++; $display("FAIL areset_rd1: got %h expected 0", rd1); end
        if (rd2 !== 32'd0)  begin miscompares++; $display("FAIL areset_rd2: got %h expected 0", rd2); end
        if (brd1 !== 32'd0) begin miscompares++; $display("FAIL areset_byp_rd1: got %h expected 0", brd1); end
        if (brd2 !== 32'd0) begin miscompares++; $display("FAIL areset_byp_rd2: got %h expected 0", brd2); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if (rd1 !== 32'd0) begin miscompares++; $display("FAIL areset_after: got %h expected 0", rd1); end
    endtask

    task automatic test_reset_collision();
        @(negedge clk); we = 1'b1; a3 = 5'd3; wd = 32'h55; tick();
        @(negedge clk);
        reset = 1'b1; clear_model();
        we = 1'b1; a3 = 5'd3; wd = 32'd9;
        tick();
        @(negedge clk);
        reset = 1'b0; we = 1'b0; a1 = 5'd3; a2 = 5'd3;
        #1;
        vectors += 2;
        if (rd1 !== 32'd0)  begin miscompares++; $display("FAIL collision: got %h expected 0", rd1); end
        if (brd2 !== 32'd0) begin miscompares++; $display("FAIL collision_byp: got %h expected 0", brd2); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            we = ($urandom_range(0, 3) != 0);
            a3 = 5'($urandom);
            if ($urandom_range(0, 7) == 0) a3 = 5'd0;
            a1 = ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom);
            a2 = ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom);
            wd = $urandom;
            #1;
            vectors += 4;
            if (rd1 !== exp_rd(a1))   begin miscompares++; $display("FAIL rand_rd1 a=%0d: got %h expected %h", a1, rd1, exp_rd(a1)); end
            if (rd2 !== exp_rd(a2))   begin miscompares++; $display("FAIL rand_rd2 a=%0d: got %h expected %h", a2, rd2, exp_rd(a2)); end
            if (brd1 !== exp_byp(a1)) begin miscompares++; $display("FAIL rand_byp_rd1 a=%0d: got %h expected %h", a1, brd1, exp_byp(a1)); end
            if (brd2 !== exp_byp(a2)) begin miscompares++; $display("FAIL rand_byp_rd2 a=%0d: got %h expected %h", a2, brd2, exp_byp(a2)); end
            tick();
        end
        @(negedge clk);
        we = 1'b0;
        for (int r = 0; r < 32; r++) begin
            a1 = 5'(r);
            a2 = 5'(31 - r);
            #1;
            vectors += 2;
            if (rd1 !== exp_rd(a1))  begin miscompares++; $display("FAIL sweep_rd1 a=%0d: got %h expected %h", a1, rd1, exp_rd(a1)); end
            if (brd2 !== exp_rd(a2)) begin miscompares++; $display("FAIL sweep_byp_rd2 a=%0d: got %h expected %h", a2, brd2, exp_rd(a2)); end
        end
    endtask

    initial begin
        reset = 1'b1;
        we = 1'b0; a1 = 5'd0; a2 = 5'd0; a3 = 5'd0; wd = 32'd0;
        clear_model();
        #12;
        test_reset();
        test_zero_reg();
        test_basic();
        test_write_disable();
        test_rdw();
        test_async_reset();
        test_reset_collision();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
